// File: rtl/ctrlpkt_cmd_splitter.sv
// Control-packet to command converter: buffers packet words and metadata in two
// sync FIFOs, then unpacks up to DATA_W/64 framed commands per packet.
`timescale 1ns/1ps

module ctrlpkt_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          Clk,
    input  logic          Reset_N,
    input  logic          wr,
    input  logic [W-1:0]  din,
    input  logic          rd,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [AW:0]   used,
    output logic          drop
);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, wr_ok, rd_ok;

    // Full is judged on the registered count, so a same-cycle read never frees room for a write.
    assign full  = (used == FULL_CNT);
    assign empty = (used == '0);
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;
    assign drop  = wr && full;

    always_ff @(posedge Clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
        if (rd_ok) dout <= mem[rd_ptr];
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   used <= used + CNT_ONE;
                2'b01:   used <= used - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

module ctrlpkt_cmd_splitter #(
    parameter int DATA_W     = 512,
    parameter int META_W     = 256,
    parameter int FIFO_DEPTH = 128,
    parameter int ALF_MARGIN = 8
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic [DATA_W-1:0] pkt_in,
    input  logic              pkt_in_wr,
    input  logic [META_W-1:0] meta_in,
    input  logic              meta_in_wr,
    output logic              pkt_in_alf,
    output logic              Command_wr,
    output logic [63:0]       Command,
    input  logic              Command_alf,
    output logic [31:0]       pkt_in_cnt,
    output logic [31:0]       com_out_cnt,
    output logic [31:0]       err_cnt
);
    localparam int MAX_CMDS = DATA_W / 64;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = $clog2(MAX_CMDS + 1);
    localparam logic [AW:0]   ALF_LEVEL = (AW+1)'(FIFO_DEPTH - ALF_MARGIN);
    localparam logic [CW-1:0] IDX_ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    state_t state, state_nxt;

    logic              fifo_rd;
    logic [DATA_W-1:0] pkt_rd;
    logic [7:0]        meta_rd;
    logic              pkt_empty, meta_empty, pkt_drop, meta_drop;
    logic [AW:0]       pkt_used, meta_used;
    logic              unused_meta_hi;

    logic [DATA_W-1:0] word_p0;
    logic [CW-1:0]     n_p0, idx_p0, n_load;
    logic              n_zero, n_clamp, last_slot, issue, bad_count;
    logic [60:0]       slot_lo;
    logic [63:0]       cmd_p1;
    logic              vld_p1;

    function automatic logic [2:0] frame_hdr(input logic [CW-1:0] idx, input logic [CW-1:0] n);
        if (n == IDX_ONE)              return 3'b100;
        else if (idx == '0)            return 3'b101;
        else if (idx == n - IDX_ONE)   return 3'b110;
        else                           return 3'b111;
    endfunction

    ctrlpkt_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .AW(AW)) u_pkt_fifo (
        .Clk(Clk), .Reset_N(Reset_N), .wr(pkt_in_wr), .din(pkt_in), .rd(fifo_rd),
        .dout(pkt_rd), .empty(pkt_empty), .used(pkt_used), .drop(pkt_drop)
    );

    // Only the command count field of the metadata is ever consumed.
    ctrlpkt_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .AW(AW)) u_meta_fifo (
        .Clk(Clk), .Reset_N(Reset_N), .wr(meta_in_wr), .din(meta_in[7:0]), .rd(fifo_rd),
        .dout(meta_rd), .empty(meta_empty), .used(meta_used), .drop(meta_drop)
    );

    assign unused_meta_hi = ^meta_in[META_W-1:8];
    assign pkt_in_alf     = (pkt_used >= ALF_LEVEL) || (meta_used >= ALF_LEVEL);

    assign n_zero    = (meta_rd == 8'd0);
    assign n_clamp   = (32'(meta_rd) > 32'(MAX_CMDS));
    assign n_load    = n_clamp ? CW'(MAX_CMDS) : CW'(meta_rd);
    assign bad_count = (state == LOAD) && (n_zero || n_clamp);
    assign issue     = (state == SEND) && !Command_alf;
    assign last_slot = (idx_p0 == n_p0 - IDX_ONE);
    assign slot_lo   = word_p0[64*idx_p0 +: 61];

    always_comb begin
        state_nxt = state;
        fifo_rd   = 1'b0;
        case (state)
            IDLE: if (!pkt_empty && !meta_empty) begin
                fifo_rd   = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: state_nxt = n_zero ? IDLE : SEND;
            SEND: if (issue && last_slot) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: packet word held for the duration of SEND
    always_ff @(posedge Clk) begin
        if (state == LOAD) word_p0 <= pkt_rd;
    end

    // Stage p1: registered command output
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state       <= IDLE;
            n_p0        <= '0;
            idx_p0      <= '0;
            vld_p1      <= 1'b0;
            cmd_p1      <= '0;
            pkt_in_cnt  <= '0;
            com_out_cnt <= '0;
            err_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                n_p0   <= n_load;
                idx_p0 <= '0;
            end else if (issue) begin
                idx_p0 <= idx_p0 + IDX_ONE;
            end
            vld_p1      <= issue;
            cmd_p1      <= issue ? {frame_hdr(idx_p0, n_p0), slot_lo} : 64'd0;
            pkt_in_cnt  <= pkt_in_cnt + 32'(meta_in_wr && !meta_drop);
            com_out_cnt <= com_out_cnt + 32'(issue);
            err_cnt     <= err_cnt + 32'(pkt_drop) + 32'(meta_drop) + 32'(bad_count);
        end
    end

    assign Command_wr = vld_p1;
    assign Command    = cmd_p1;
endmodule

// File: tb/tb_ctrlpkt_cmd_splitter.sv
// Scoreboard bench for ctrlpkt_cmd_splitter: directed packets push expected
// commands; a negedge monitor pops and compares every Command_wr.
`timescale 1ns/1ps

module tb_ctrlpkt_cmd_splitter;
    localparam int DATA_W     = 512;
    localparam int META_W     = 256;
    localparam int FIFO_DEPTH = 128;
    localparam int ALF_MARGIN = 8;

    logic              Clk = 1'b0;
    logic              Reset_N = 1'b0;
    logic [DATA_W-1:0] pkt_in = '0;
    logic              pkt_in_wr = 1'b0;
    logic [META_W-1:0] meta_in = '0;
    logic              meta_in_wr = 1'b0;
    logic              pkt_in_alf;
    logic              Command_wr;
    logic [63:0]       Command;
    logic              Command_alf = 1'b0;
    logic [31:0]       pkt_in_cnt, com_out_cnt, err_cnt;

    ctrlpkt_cmd_splitter #(
        .DATA_W(DATA_W), .META_W(META_W), .FIFO_DEPTH(FIFO_DEPTH), .ALF_MARGIN(ALF_MARGIN)
    ) dut (
        .Clk(Clk), .Reset_N(Reset_N), .pkt_in(pkt_in), .pkt_in_wr(pkt_in_wr),
        .meta_in(meta_in), .meta_in_wr(meta_in_wr), .pkt_in_alf(pkt_in_alf),
        .Command_wr(Command_wr), .Command(Command), .Command_alf(Command_alf),
        .pkt_in_cnt(pkt_in_cnt), .com_out_cnt(com_out_cnt), .err_cnt(err_cnt)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    int          seen_cyc[$];
    bit          lat_arm = 1'b0;
    int          first_cyc = 0;
    logic [31:0] exp_pkt = 0, exp_cmd = 0, exp_err = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (Command_wr === 1'b1) begin
            seen_cyc.push_back(cyc);
            if (lat_arm) begin
                first_cyc = cyc;
                lat_arm   = 1'b0;
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cmd actual=%h required=none", Command);
            end else begin
                check64("cmd", Command, exp_q.pop_front());
            end
        end else begin
            check64("cmd_zero_when_idle", Command, 64'd0);
        end
    end

    task automatic write_pkt(input logic [DATA_W-1:0] w, input logic [7:0] n);
        @(negedge Clk);
        pkt_in     = w;
        meta_in    = {{(META_W-8){1'b1}}, n};
        pkt_in_wr  = 1'b1;
        meta_in_wr = 1'b1;
        @(negedge Clk);
        pkt_in_wr  = 1'b0;
        meta_in_wr = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge Clk);
            i++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge Clk);
    endtask

    task automatic check_counters(input string name);
        check64({name, "_pkt_in_cnt"}, 64'(pkt_in_cnt), 64'(exp_pkt));
        check64({name, "_com_out_cnt"}, 64'(com_out_cnt), 64'(exp_cmd));
        check64({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] w;
        logic [63:0]       s;
        logic [2:0]        h;
        int                t0;

        repeat (3) @(negedge Clk);
        check64("rst_command_wr", 64'(Command_wr), 64'd0);
        check64("rst_command", Command, 64'd0);
        check64("rst_pkt_in_alf", 64'(pkt_in_alf), 64'd0);
        check_counters("rst");
        Reset_N = 1'b1;
        repeat (2) @(negedge Clk);

        // Single command; top slot bits must be replaced by the 100 header.
        w = '0;
        w[63:0]   = 64'h1FFF_0000_1234_5678;
        w[127:64] = 64'hDEAD_BEEF_DEAD_BEEF;
        exp_q.push_back(64'h9FFF_0000_1234_5678);
        lat_arm = 1'b1;
        write_pkt(w, 8'd1);
        t0 = cyc;
        exp_pkt += 1; exp_cmd += 1;
        wait_drain(50, "t1_drain");
        check64("t1_latency", 64'(first_cyc - t0), 64'd3);
        check_counters("t1");

        // Three commands back to back.
        seen_cyc.delete();
        w = '0;
        w[63:0]    = 64'h0000_0000_0000_AAAA;
        w[127:64]  = 64'h0000_0000_0000_BBBB;
        w[191:128] = 64'h0000_0000_0000_CCCC;
        exp_q.push_back(64'hA000_0000_0000_AAAA);
        exp_q.push_back(64'hE000_0000_0000_BBBB);
        exp_q.push_back(64'hC000_0000_0000_CCCC);
        write_pkt(w, 8'd3);
        exp_pkt += 1; exp_cmd += 3;
        wait_drain(50, "t2_drain");
        check64("t2_spacing", 64'((seen_cyc.size() == 3) ? seen_cyc[2] - seen_cyc[0] : -1), 64'd2);
        check_counters("t2");

        // Three commands with Command_alf high during cycles 4-6.
        seen_cyc.delete();
        w = '0;
        w[63:0]    = 64'h0000_0000_0000_0D0D;
        w[127:64]  = 64'h0000_0000_0000_0E0E;
        w[191:128] = 64'h0000_0000_0000_0F0F;
        exp_q.push_back(64'hA000_0000_0000_0D0D);
        exp_q.push_back(64'hE000_0000_0000_0E0E);
        exp_q.push_back(64'hC000_0000_0000_0F0F);
        write_pkt(w, 8'd3);
        t0 = cyc;
        repeat (4) @(negedge Clk);
        Command_alf = 1'b1;
        repeat (3) @(negedge Clk);
        Command_alf = 1'b0;
        exp_pkt += 1; exp_cmd += 3;
        wait_drain(50, "t3_drain");
        check64("t3_second_cycle", 64'((seen_cyc.size() == 3) ? seen_cyc[1] - t0 : -1), 64'd4);
        check64("t3_third_cycle", 64'((seen_cyc.size() == 3) ? seen_cyc[2] - t0 : -1), 64'd8);
        check_counters("t3");

        // Zero-count packet, then a count of 20 clamped to 8.
        w = '0;
        w[63:0] = 64'h0000_0000_0000_5555;
        write_pkt(w, 8'd0);
        w = '0;
        for (int i = 0; i < 8; i++) begin
            s = 64'h1234_5678_0000_0000 | 64'(i);
            w[64*i +: 64] = s;
            h = (i == 0) ? 3'b101 : (i == 7) ? 3'b110 : 3'b111;
            exp_q.push_back({h, s[60:0]});
        end
        write_pkt(w, 8'd20);
        exp_pkt += 2; exp_cmd += 8; exp_err += 2;
        wait_drain(100, "t4_drain");
        check_counters("t4");

        // Block the splitter, then overflow both FIFOs by two writes.
        Command_alf = 1'b1;
        w = '0;
        w[63:0] = 64'h0000_0000_0000_B10C;
        exp_q.push_back(64'h8000_0000_0000_B10C);
        write_pkt(w, 8'd1);
        repeat (5) @(negedge Clk);
        for (int k = 0; k < 130; k++) begin
            @(negedge Clk);
            if (k == 119) check64("t5_alf_at_119", 64'(pkt_in_alf), 64'd0);
            if (k == 120) check64("t5_alf_at_120", 64'(pkt_in_alf), 64'd1);
            s = 64'hF000_0000_0000_0000 | 64'(k);
            pkt_in     = DATA_W'(s);
            meta_in    = META_W'(8'd1);
            pkt_in_wr  = 1'b1;
            meta_in_wr = 1'b1;
            if (k < 128) exp_q.push_back({3'b100, s[60:0]});
        end
        @(negedge Clk);
        pkt_in_wr  = 1'b0;
        meta_in_wr = 1'b0;
        @(negedge Clk);
        exp_pkt += 129; exp_err += 4;
        check64("t5_alf_full", 64'(pkt_in_alf), 64'd1);
        check64("t5_err_cnt", 64'(err_cnt), 64'(exp_err));
        check64("t5_pkt_in_cnt", 64'(pkt_in_cnt), 64'(exp_pkt));
        Command_alf = 1'b0;
        exp_cmd += 129;
        wait_drain(2000, "t5_drain");
        check_counters("t5");
        check64("t5_alf_drained", 64'(pkt_in_alf), 64'd0);

        // Reset after two of five commands.
        w = '0;
        for (int i = 0; i < 5; i++) w[64*i +: 64] = 64'h0000_0000_0000_7700 | 64'(i);
        exp_q.push_back(64'hA000_0000_0000_7700);
        exp_q.push_back(64'hE000_0000_0000_7701);
        write_pkt(w, 8'd5);
        repeat (4) @(negedge Clk);
        #1 Reset_N = 1'b0;
        #1;
        exp_pkt = 0; exp_cmd = 0; exp_err = 0;
        check64("t6_rst_command_wr", 64'(Command_wr), 64'd0);
        check64("t6_rst_command", Command, 64'd0);
        check64("t6_rst_alf", 64'(pkt_in_alf), 64'd0);
        check_counters("t6_rst");
        check64("t6_two_seen", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge Clk);
        Reset_N = 1'b1;
        repeat (20) @(negedge Clk);
        check_counters("t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
